up_sampler: RTL and testbench

- 2x nearest-neighbour up-sampler that drains the Gaussian-stage output FIFO: it drives rd_en and consumes empty, valid and dout.
- Each input pixel is emitted twice horizontally. Each input row is emitted twice vertically, with the repeat replayed from an internal line buffer.
- Feeds the downstream octave/compare stage through a valid/ready stream carrying end-of-line and end-of-frame markers.

---
 rtl/up_sampler.sv | 170 +++++++++++++++++
 tb/tb_up_sampler.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/up_sampler.sv
// 2x nearest-neighbour up-sampler draining a standard (non-FWFT) FIFO.
// Row copy A comes from the FIFO, copy B is replayed from a line buffer.
module up_sampler #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic       fifo_valid,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd_en,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_eol,
  output logic       out_eof
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int NW = $clog2(IMG_WIDTH + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [NW-1:0] RD_MAX   = NW'(IMG_WIDTH);

  typedef enum logic {
    ROW_A = 1'b0,
    ROW_B = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] wr_col_q, wr_col_d;
  logic [RW-1:0] row_q, row_d;
  logic          phase_q, phase_d;
  logic          hold_valid_q, hold_valid_d;
  logic [7:0]    hold_pix_q, hold_pix_d;
  logic          rd_pending_q, rd_pending_d;
  logic [NW-1:0] rd_cnt_q, rd_cnt_d;

  logic [7:0] linebuf [IMG_WIDTH];

  logic       vld;
  logic [7:0] pix;
  logic       accept;
  logic       last_pix;
  logic       load;
  logic       rows_issued_ok;
  logic       rd_en;

  // Output view of the current pixel and handshake qualifiers.
  always_comb begin
    vld = 1'b0;
    pix = 8'd0;
    unique case (state_q)
      ROW_A: begin
        vld = hold_valid_q;
        pix = hold_pix_q;
      end
      ROW_B: begin
        vld = 1'b1;
        pix = linebuf[col_q];
      end
      default: begin
        vld = 1'b0;
        pix = 8'd0;
      end
    endcase
    accept         = vld & out_ready;
    last_pix       = phase_q & (col_q == COL_LAST);
    load           = fifo_valid & rd_pending_q;
    rows_issued_ok = (rd_cnt_q != RD_MAX);
    rd_en = (state_q == ROW_A) & !fifo_empty
          & !rd_pending_q & rows_issued_ok
          & (!hold_valid_q | (phase_q & accept));
  end

  // Ports are forced quiet while reset is held.
  always_comb begin
    fifo_rd_en = rd_en & !rst;
    out_valid  = vld & !rst;
    out_data   = rst ? 8'd0 : pix;
    out_eol    = vld & last_pix & !rst;
    out_eof    = vld & last_pix & !rst
               & (state_q == ROW_B)
               & (row_q == ROW_LAST);
  end

  // Next-state: read tracking, pixel hold, phase/col/row stepping.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    wr_col_d     = wr_col_q;
    row_d        = row_q;
    phase_d      = phase_q;
    hold_valid_d = hold_valid_q;
    hold_pix_d   = hold_pix_q;
    rd_pending_d = rd_pending_q;
    rd_cnt_d     = rd_cnt_q;

    if (rd_en) begin
      rd_pending_d = 1'b1;
      rd_cnt_d     = rd_cnt_q + NW'(1);
    end
    if (load) begin
      rd_pending_d = 1'b0;
    end

    if (accept) begin
      phase_d = ~phase_q;
      if (phase_q) begin
        col_d = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
        if (state_q == ROW_A) begin
          hold_valid_d = 1'b0;
        end
      end
      if (last_pix) begin
        if (state_q == ROW_A) begin
          state_d = ROW_B;
        end else begin
          state_d  = ROW_A;
          rd_cnt_d = '0;
          row_d    = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
        end
      end
    end

    // A fresh pixel wins over a same-cycle release of the old one.
    if (load) begin
      hold_pix_d   = fifo_dout;
      hold_valid_d = 1'b1;
      wr_col_d     = (wr_col_q == COL_LAST) ? '0 : wr_col_q + CW'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ROW_A;
      col_q        <= '0;
      wr_col_q     <= '0;
      row_q        <= '0;
      phase_q      <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_pix_q   <= 8'd0;
      rd_pending_q <= 1'b0;
      rd_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      wr_col_q     <= wr_col_d;
      row_q        <= row_d;
      phase_q      <= phase_d;
      hold_valid_q <= hold_valid_d;
      hold_pix_q   <= hold_pix_d;
      rd_pending_q <= rd_pending_d;
      rd_cnt_q     <= rd_cnt_d;
    end
  end

  // Line buffer captures every FIFO pixel of copy A for the replay.
  always_ff @(posedge clk) begin
    if (load && !rst) begin
      linebuf[wr_col_q] <= fifo_dout;
    end
  end

endmodule

// File: tb/tb_up_sampler.sv
// Bench for up_sampler: FIFO model, scoreboard queue,
// table of rows with expected pixel streams.
module tb_up_sampler;

  localparam int W = 4;
  localparam int H = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty;
  logic       fifo_valid;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_eol;
  logic       out_eof;

  up_sampler #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_valid(fifo_valid),
    .fifo_dout (fifo_dout),
    .fifo_rd_en(fifo_rd_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_eol   (out_eol),
    .out_eof   (out_eof)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pix [W];
    logic [7:0] exp [2*W];
    int         row;
    bit         toggle;
    int         gap;
    bit         spur_b;
  } vec_t;

  typedef struct packed {
    logic [7:0] data;
    logic       eol;
    logic       eof;
  } exp_t;

  vec_t       vec [7];
  exp_t       exp_q [$];
  logic [7:0] fifo_q [$];

  int   checks = 0;
  int   errors = 0;
  int   acc_cnt = 0;
  int   rd_total = 0;
  bit   toggle_mode = 0;
  logic spur = 1'b0;
  logic fv_m = 1'b0;
  logic [7:0] fd_m = 8'd0;

  assign fifo_valid = fv_m | spur;
  assign fifo_dout  = spur ? 8'hFF : fd_m;
  assign fifo_empty = (fifo_q.size() == 0);

  // Standard FIFO: data and valid one cycle after an accepted read.
  always @(posedge clk) begin
    if (rst) begin
      fv_m <= 1'b0;
      fd_m <= 8'd0;
    end else begin
      fv_m <= 1'b0;
      if (fifo_rd_en && fifo_q.size() != 0) begin
        fd_m     <= fifo_q.pop_front();
        fv_m     <= 1'b1;
        rd_total <= rd_total + 1;
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    out_ready = toggle_mode ? ~out_ready : 1'b1;
  end

  logic       stall_p = 1'b0;
  logic [7:0] d_p;
  logic       eol_p, eof_p;
  exp_t       e;

  always @(negedge clk) begin
    if (rst) begin
      acc_cnt = 0;
      stall_p = 1'b0;
    end else begin
      if (stall_p) begin
        checks++;
        if (!out_valid || out_data != d_p
            || out_eol != eol_p || out_eof != eof_p) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b d=%0d eol=%0b eof=%0b, want v=1 d=%0d eol=%0b eof=%0b",
                   out_valid, out_data, out_eol, out_eof, d_p, eol_p, eof_p);
        end
      end
      if (fifo_rd_en) begin
        checks++;
        if (fifo_empty || fv_m) begin
          errors++;
          $display("FAIL rd_guard: rd_en=1 with empty=%0b pending_valid=%0b, want both 0",
                   fifo_empty, fv_m);
        end
      end
      if ((acc_cnt % (4*W)) >= 2*W) begin
        checks++;
        if (fifo_rd_en) begin
          errors++;
          $display("FAIL rowb_read: rd_en=1 during replay row, want 0");
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel: got d=%0d, want no output", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data != e.data || out_eol != e.eol || out_eof != e.eof) begin
            errors++;
            $display("FAIL pixel[%0d]: got d=%0d eol=%0b eof=%0b, want d=%0d eol=%0b eof=%0b",
                     acc_cnt, out_data, out_eol, out_eof, e.data, e.eol, e.eof);
          end
        end
        acc_cnt++;
      end
      stall_p = out_valid & !out_ready;
      d_p     = out_data;
      eol_p   = out_eol;
      eof_p   = out_eof;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input vec_t v);
    exp_t x;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 2*W; i++) begin
        x.data = v.exp[i];
        x.eol  = (i == 2*W-1);
        x.eof  = (c == 1) && (i == 2*W-1) && (v.row == H-1);
        exp_q.push_back(x);
      end
    end
  endtask

  task automatic wait_rd(input int target);
    for (int n = 0; n < 300 && rd_total < target; n++) tick();
    checks++;
    if (rd_total < target) begin
      errors++;
      $display("FAIL wait_rd: got %0d reads, want %0d", rd_total, target);
    end
  endtask

  task automatic wait_exp(input int left);
    for (int n = 0; n < 300 && exp_q.size() > left; n++) tick();
    checks++;
    if (exp_q.size() > left) begin
      errors++;
      $display("FAIL wait_out: got %0d pending, want %0d", exp_q.size(), left);
    end
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 400 && (exp_q.size() != 0 || fifo_q.size() != 0); n++)
      tick();
    checks++;
    if (exp_q.size() != 0 || fifo_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pixels and %0d fifo words left, want 0 and 0",
               exp_q.size(), fifo_q.size());
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (out_valid || out_data != 8'd0 || out_eol || out_eof || fifo_rd_en) begin
      errors++;
      $display("FAIL %s: got v=%0b d=%0d eol=%0b eof=%0b rd=%0b, want all 0",
               tag, out_valid, out_data, out_eol, out_eof, fifo_rd_en);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want finish");
    $fatal(1);
  end

  int base;

  initial begin
    vec[0].pix = '{8'd10, 8'd20, 8'd30, 8'd40};
    vec[0].exp = '{8'd10, 8'd10, 8'd20, 8'd20, 8'd30, 8'd30, 8'd40, 8'd40};
    vec[0].row = 0; vec[0].toggle = 0; vec[0].gap = 0; vec[0].spur_b = 0;
    vec[1].pix = '{8'd50, 8'd60, 8'd70, 8'd80};
    vec[1].exp = '{8'd50, 8'd50, 8'd60, 8'd60, 8'd70, 8'd70, 8'd80, 8'd80};
    vec[1].row = 1; vec[1].toggle = 0; vec[1].gap = 0; vec[1].spur_b = 0;
    vec[2] = vec[0]; vec[2].toggle = 1; vec[2].spur_b = 1;
    vec[3] = vec[1]; vec[3].toggle = 1;
    vec[4] = vec[0]; vec[4].gap = 2;
    vec[5] = vec[1];
    vec[6].pix = '{8'd1, 8'd2, 8'd3, 8'd4};
    vec[6].exp = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4, 8'd4};
    vec[6].row = 0; vec[6].toggle = 0; vec[6].gap = 0; vec[6].spur_b = 0;

    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_zero("reset_out");
    end
    tick();
    rst = 1'b0;

    for (int k = 0; k < 6; k++) begin
      toggle_mode = vec[k].toggle;
      base = rd_total;
      push_exp(vec[k]);
      if (vec[k].gap == 0) begin
        for (int i = 0; i < W; i++) fifo_q.push_back(vec[k].pix[i]);
      end else begin
        for (int i = 0; i < vec[k].gap; i++) fifo_q.push_back(vec[k].pix[i]);
        wait_rd(base + vec[k].gap);
        wait_exp(4*W - 2*vec[k].gap);
        for (int i = 0; i < 10; i++) begin
          tick();
          spur = (i == 3);
          @(negedge clk);
          checks++;
          if (out_valid || fifo_rd_en) begin
            errors++;
            $display("FAIL gap_idle: got v=%0b rd=%0b, want 0 0", out_valid, fifo_rd_en);
          end
        end
        spur = 1'b0;
        for (int i = vec[k].gap; i < W; i++) fifo_q.push_back(vec[k].pix[i]);
      end
      if (vec[k].spur_b) begin
        wait_rd(base + W);
        tick();
        spur = 1'b1;
        tick();
        spur = 1'b0;
      end
      wait_drain();
    end
    toggle_mode = 0;
    repeat (2) tick();

    // Reset in the middle of a row, then a fresh frame.
    base = acc_cnt;
    push_exp(vec[0]);
    for (int i = 0; i < W; i++) fifo_q.push_back(vec[0].pix[i]);
    for (int n = 0; n < 200 && acc_cnt < base + 5; n++) tick();
    checks++;
    if (acc_cnt < base + 5) begin
      errors++;
      $display("FAIL pre_reset: got %0d pixels, want %0d", acc_cnt - base, 5);
    end
    rst = 1'b1;
    exp_q.delete();
    fifo_q.delete();
    repeat (3) begin
      @(negedge clk);
      check_zero("mid_reset");
    end
    tick();
    rst = 1'b0;
    spur = 1'b1;
    tick();
    spur = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_zero("stray_valid");
    end
    tick();
    push_exp(vec[6]);
    push_exp(vec[1]);
    for (int i = 0; i < W; i++) fifo_q.push_back(vec[6].pix[i]);
    for (int i = 0; i < W; i++) fifo_q.push_back(vec[1].pix[i]);
    wait_drain();
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
